// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the RV64I single-cycle datapath.
// Loads are combinational. Stores commit on the clock edge. Faulting accesses are suppressed and recorded.
module data_memory #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned AW          = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] mem_addr,
  input  logic [63:0]   write_data,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    funct3,
  output logic [63:0]   read_data,
  output logic          misaligned,
  output logic          out_of_range,
  output logic          err_sticky
);

  localparam int unsigned IW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [3:0]    nbytes;
  logic          en;
  logic          illegal;
  logic          fault;
  logic [AW:0]   last_addr;
  logic [IW-1:0] base;
  logic [63:0]   raw;

  // The last byte address is computed one bit wider, so addresses near 2^AW cannot wrap back into range.
  always_comb begin
    nbytes       = 4'd1 << funct3[1:0];
    en           = mem_read | mem_write;
    last_addr    = {1'b0, mem_addr} + (AW+1)'(nbytes - 4'd1);
    misaligned   = en && ((mem_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0);
    out_of_range = en && (last_addr >= (AW+1)'(DEPTH_BYTES));
    illegal      = en && ((funct3 == 3'b111) || (mem_write && funct3[2]));
    fault        = misaligned | out_of_range | illegal;
    base         = mem_addr[IW-1:0];
  end

  // The gather wraps within the array. Any access whose bytes would wrap is already a fault and returns zero.
  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < 8; i++)
      raw[8*i +: 8] = mem[base + IW'(i)];
  end

  always_comb begin
    read_data = '0;
    if (mem_read && !fault) begin
      unique case (funct3[1:0])
        2'd0: read_data = funct3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
        2'd1: read_data = funct3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
        2'd2: read_data = funct3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
        2'd3: read_data = raw;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++)
        mem[IW'(i)] <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (mem_write && !fault) begin
        for (int unsigned i = 0; i < 8; i++)
          if (i < {28'd0, nbytes})
            mem[base + IW'(i)] <= write_data[8*i +: 8];
      end
      if (fault)
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory against a byte-array reference model.
module tb_data_memory;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mem_addr;
  logic [63:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] read_data;
  logic        misaligned;
  logic        out_of_range;
  logic        err_sticky;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] ref_mem [DEPTH];
  logic       ref_sticky;

  data_memory #(.DEPTH_BYTES(DEPTH), .AW(64)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .read_data(read_data), .misaligned(misaligned), .out_of_range(out_of_range),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  // One access cycle. Outputs are checked against the model before the edge, the model is updated, and err_sticky is checked after the edge.
  task automatic access(input logic rst, input logic [63:0] a, input logic [63:0] wd,
                        input logic rd, input logic wr, input logic [2:0] f,
                        output logic [63:0] o_rd, output logic o_mis, output logic o_oor);
    longint unsigned size, addr, v;
    logic e_mis, e_oor, e_ill, e_fault;
    addr = a;
    size = 64'd1 << f[1:0];
    reset = rst; mem_addr = a; write_data = wd; mem_read = rd; mem_write = wr; funct3 = f;
    #1;
    e_mis   = (rd || wr) && (addr % size != 0);
    e_oor   = (rd || wr) && (addr > DEPTH - size);
    e_ill   = (rd || wr) && (f == 3'b111 || (wr && f[2]));
    e_fault = e_mis || e_oor || e_ill;
    v = 0;
    if (rd && !e_fault) begin
      for (int k = 0; k < int'(size); k++)
        v = v | (longint'(ref_mem[int'(addr) + k]) << (8 * k));
      if (!f[2] && size < 8 && v[8*size-1])
        v = v | ~((64'd1 << (8 * size)) - 1);
    end
    check("misaligned", {63'd0, misaligned}, {63'd0, e_mis});
    check("out_of_range", {63'd0, out_of_range}, {63'd0, e_oor});
    check("read_data", read_data, v);
    o_rd = read_data; o_mis = misaligned; o_oor = out_of_range;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = 8'h00;
      ref_sticky = 1'b0;
    end else begin
      if (wr && !e_fault)
        for (int k = 0; k < int'(size); k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
      if (e_fault) ref_sticky = 1'b1;
    end
    check("err_sticky", {63'd0, err_sticky}, {63'd0, ref_sticky});
  endtask

  initial begin
    logic [63:0] r;
    logic m, o;
    longint unsigned ra;
    int unsigned sel;
    reset = 1'b0; mem_addr = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    ref_sticky = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = 8'h00;
    @(posedge clk); #1;

    access(1, 0, 0, 0, 0, 3'd3, r, m, o);
    access(0, 64'h10, 0, 1, 0, 3'd3, r, m, o);
    check("ld10_after_reset", r, 64'h0);
    check("sticky_after_reset", {63'd0, err_sticky}, 64'h0);

    access(0, 64'h08, 64'h8877665544332211, 0, 1, 3'd3, r, m, o);
    access(0, 64'h08, 0, 1, 0, 3'd0, r, m, o); check("lb08", r, 64'h0000000000000011);
    access(0, 64'h0A, 0, 1, 0, 3'd1, r, m, o); check("lh0a", r, 64'h0000000000004433);
    access(0, 64'h0C, 0, 1, 0, 3'd6, r, m, o); check("lwu0c", r, 64'h0000000088776655);
    access(0, 64'h0C, 0, 1, 0, 3'd2, r, m, o); check("lw0c", r, 64'hFFFFFFFF88776655);
    access(0, 64'h0F, 0, 1, 0, 3'd0, r, m, o); check("lb0f", r, 64'hFFFFFFFFFFFFFF88);

    access(0, 64'h09, 64'hAB, 0, 1, 3'd0, r, m, o);
    access(0, 64'h08, 0, 1, 0, 3'd3, r, m, o); check("ld08_after_sb", r, 64'h887766554433AB11);

    access(0, 64'h06, 64'hDEADBEEF, 0, 1, 3'd2, r, m, o);
    check("sw06_misaligned", {63'd0, m}, 64'h1);
    check("sw06_sticky", {63'd0, err_sticky}, 64'h1);
    access(0, 64'h04, 0, 1, 0, 3'd6, r, m, o); check("lwu04_unchanged", r, 64'h0);
    access(0, 64'h08, 0, 1, 0, 3'd3, r, m, o); check("ld08_unchanged", r, 64'h887766554433AB11);
    check("sticky_held", {63'd0, err_sticky}, 64'h1);

    access(0, 64'hFC, 0, 1, 0, 3'd3, r, m, o);
    check("ldfc_oor", {63'd0, o}, 64'h1);
    check("ldfc_data", r, 64'h0);
    access(0, 64'hFFFFFFFFFFFFFFF8, 0, 1, 0, 3'd3, r, m, o);
    check("ld_top_oor", {63'd0, o}, 64'h1);
    access(0, 64'hF8, 0, 1, 0, 3'd3, r, m, o);
    check("ldf8_in_range", {63'd0, o}, 64'h0);

    access(0, 64'h00, 64'h1, 0, 1, 3'd3, r, m, o);
    access(1, 64'h00, 64'h1, 0, 1, 3'd3, r, m, o);
    access(0, 64'h00, 0, 1, 0, 3'd3, r, m, o); check("ld00_after_reset_store", r, 64'h0);
    check("sticky_cleared", {63'd0, err_sticky}, 64'h0);

    access(0, 64'h20, 64'h1234, 0, 1, 3'd3, r, m, o);
    access(0, 64'h20, 64'hCAFE, 1, 1, 3'd3, r, m, o); check("ld20_old", r, 64'h1234);
    access(0, 64'h20, 0, 1, 0, 3'd3, r, m, o); check("ld20_new", r, 64'hCAFE);

    access(0, 64'h30, 0, 1, 0, 3'd7, r, m, o); check("ld_f3_111", r, 64'h0);
    check("sticky_illegal", {63'd0, err_sticky}, 64'h1);

    for (int it = 0; it < 500; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       ra = longint'($urandom_range(0, 255));
      else if (sel == 8) ra = longint'($urandom_range(240, 270));
      else               ra = {$urandom, $urandom};
      access(($urandom_range(0, 49) == 0), ra, {$urandom, $urandom},
             1'($urandom), 1'($urandom), 3'($urandom), r, m, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
